// File: rtl/icf3z_intc.sv
// Purpose : 8-source interrupt controller feeding the icf3z core INT0/INT1 pins,
//           programmed through the core I/O port bus (PORTID/OUTPORT/WSTROBE/RDATA).
// Latency : IRQ sampled high at edge 1 -> PEND at edge 3 -> INT at edge 4; reads 1 edge.
// Backpressure: none; every strobed write is honoured, back-to-back writes included.
//
// Ports:
//   CLK       rising-edge clock
//   xRESET_P  synchronous active-high reset
//   IRQ_IN    asynchronous request lines, bit n = source n
//   PORTID    core port address; registers live at BASE+0..BASE+3
//   OUTPORT   core write data
//   WSTROBE   one-cycle core write strobe
//   RDATA     registered read data toward the core INPORT mux
//   INT0/1    registered active-high interrupt levels to the core
//
// Register map (BASE must be a multiple of 4):
//   +0 PEND  R/W1C   +1 MASK RW   +2 ROUTE RW (1=INT1)   +3 EDGE RW (1=rising edge)

module icf3z_intc #(
  parameter logic [7:0] BASE = 8'h10
) (
  input  logic       CLK,
  input  logic       xRESET_P,
  input  logic [7:0] IRQ_IN,
  input  logic [7:0] PORTID,
  input  logic [7:0] OUTPORT,
  input  logic       WSTROBE,
  output logic [7:0] RDATA,
  output logic       INT0,
  output logic       INT1
);

  localparam logic [1:0] OFF_PEND  = 2'd0;
  localparam logic [1:0] OFF_MASK  = 2'd1;
  localparam logic [1:0] OFF_ROUTE = 2'd2;
  localparam logic [1:0] OFF_EDGE  = 2'd3;

  // Synchroniser chain plus one history stage for edge detection.
  logic [7:0] s1;
  logic [7:0] s2;
  logic [7:0] s3;

  // Programmable state.
  logic [7:0] pend;
  logic [7:0] mask;
  logic [7:0] route;
  logic [7:0] edge_mode;

  // Decode and next-state terms.
  logic       hit;
  logic       wr;
  logic [7:0] rise;
  logic [7:0] set_vec;
  logic [7:0] clr_vec;
  logic [7:0] pend_nxt;
  logic [7:0] rd_mux;

  // Only the upper six address bits select this controller; the low two
  // bits pick the register, so the whole 4-port window is claimed.
  assign hit = (PORTID[7:2] == BASE[7:2]);
  assign wr  = WSTROBE & hit;

  assign rise    = s2 & ~s3;
  assign set_vec = (edge_mode & rise) | (~edge_mode & s2);
  assign clr_vec = (wr && (PORTID[1:0] == OFF_PEND)) ? OUTPORT : 8'h00;

  // Set has priority over a same-cycle clear, so a request arriving exactly
  // on the W1C cycle is never lost. Level sources keep re-setting while high.
  assign pend_nxt = set_vec | (pend & ~clr_vec);

  always_comb begin
    rd_mux = 8'h00;
    if (hit) begin
      case (PORTID[1:0])
        OFF_PEND:  rd_mux = pend;
        OFF_MASK:  rd_mux = mask;
        OFF_ROUTE: rd_mux = route;
        OFF_EDGE:  rd_mux = edge_mode;
        default:   rd_mux = 8'h00;
      endcase
    end
  end

  // s3 keeps tracking s2 regardless of EDGE, so switching a source into edge
  // mode while its line is high does not fabricate an edge. After reset s3 is
  // 0, so a line held high through reset release is seen as a rising edge.
  always_ff @(posedge CLK) begin
    if (xRESET_P) begin
      s1 <= 8'h00;
      s2 <= 8'h00;
      s3 <= 8'h00;
    end else begin
      s1 <= IRQ_IN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Pending latches regardless of MASK; masking only gates the INT outputs.
  always_ff @(posedge CLK) begin
    if (xRESET_P) begin
      pend <= 8'h00;
    end else begin
      pend <= pend_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (xRESET_P) begin
      mask      <= 8'h00;
      route     <= 8'h00;
      edge_mode <= 8'h00;
    end else if (wr) begin
      case (PORTID[1:0])
        OFF_MASK:  mask      <= OUTPORT;
        OFF_ROUTE: route     <= OUTPORT;
        OFF_EDGE:  edge_mode <= OUTPORT;
        default:   ;
      endcase
    end
  end

  // Outputs are registered from current state: INT follows PEND one edge later,
  // and RDATA reflects the register addressed before the edge.
  always_ff @(posedge CLK) begin
    if (xRESET_P) begin
      RDATA <= 8'h00;
      INT0  <= 1'b0;
      INT1  <= 1'b0;
    end else begin
      RDATA <= rd_mux;
      INT0  <= |(pend & mask & ~route);
      INT1  <= |(pend & mask & route);
    end
  end

endmodule

// File: tb/tb_icf3z_intc.sv
// Purpose : self-checking bench for icf3z_intc with a read-data scoreboard.
// Latency : inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: not applicable; the bench owns the port bus.

module tb_icf3z_intc;

  logic       CLK;
  logic       xRESET_P;
  logic [7:0] IRQ_IN;
  logic [7:0] PORTID;
  logic [7:0] OUTPORT;
  logic       WSTROBE;
  logic [7:0] RDATA;
  logic       INT0;
  logic       INT1;

  int total = 0;
  int bad   = 0;

  // Expected RDATA values, pushed when the address is driven and popped once
  // the registered read data for that edge is visible.
  logic [7:0] rd_q[$];

  icf3z_intc #(.BASE(8'h10)) dut (
    .CLK      (CLK),
    .xRESET_P (xRESET_P),
    .IRQ_IN   (IRQ_IN),
    .PORTID   (PORTID),
    .OUTPORT  (OUTPORT),
    .WSTROBE  (WSTROBE),
    .RDATA    (RDATA),
    .INT0     (INT0),
    .INT1     (INT1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One edge with the current PORTID, checking the read data it produces.
  task automatic step(input string tag, input logic [7:0] exp);
    rd_q.push_back(exp);
    tick();
    chk(tag, RDATA, rd_q.pop_front());
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    PORTID  = addr;
    OUTPORT = data;
    WSTROBE = 1'b1;
    tick();
    WSTROBE = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    PORTID = addr;
    step(tag, exp);
  endtask

  task automatic pulse(input logic [7:0] bits, input int n);
    IRQ_IN = bits;
    repeat (n) tick();
    IRQ_IN = 8'h00;
    repeat (3) tick();
  endtask

  initial begin
    xRESET_P = 1'b1;
    IRQ_IN   = 8'hFF;
    PORTID   = 8'h10;
    OUTPORT  = 8'h00;
    WSTROBE  = 1'b0;

    // Reset with all requests high: outputs held at zero.
    tick();
    tick();
    chk("rst_rdata", RDATA, 8'h00);
    chk("rst_int0", {7'b0, INT0}, 8'h00);
    chk("rst_int1", {7'b0, INT1}, 8'h00);

    // Release with lines still high: seen as rising edges, MASK=0 keeps INT low.
    xRESET_P = 1'b0;
    wr(8'h13, 8'hFF);
    repeat (4) tick();
    rd("post_rst_pend", 8'h10, 8'hFF);
    chk("post_rst_int0", {7'b0, INT0}, 8'h00);
    chk("post_rst_int1", {7'b0, INT1}, 8'h00);
    // Edge mode with lines still high: a clear sticks.
    wr(8'h10, 8'hFF);
    rd("edge_clr_sticks", 8'h10, 8'h00);
    IRQ_IN = 8'h00;
    repeat (3) tick();

    // Edge latency on source 0.
    wr(8'h11, 8'h01);
    wr(8'h13, 8'h01);
    wr(8'h12, 8'h00);
    PORTID = 8'h10;
    IRQ_IN = 8'h01;
    step("lat_e1", 8'h00);
    step("lat_e2", 8'h00);
    step("lat_e3", 8'h00);
    chk("lat_int0_e3", {7'b0, INT0}, 8'h00);
    IRQ_IN = 8'h00;
    step("lat_e4_pend", 8'h01);
    chk("lat_int0_e4", {7'b0, INT0}, 8'h01);
    repeat (3) tick();
    chk("lat_int0_hold", {7'b0, INT0}, 8'h01);
    wr(8'h10, 8'h01);
    chk("lat_int0_clr_k", {7'b0, INT0}, 8'h01);
    tick();
    chk("lat_int0_clr_k1", {7'b0, INT0}, 8'h00);

    // Routing: bit 1 -> INT0, bit 7 -> INT1.
    wr(8'h11, 8'h82);
    wr(8'h12, 8'h80);
    wr(8'h13, 8'hFF);
    pulse(8'h02, 2);
    chk("rt_int0_b1", {7'b0, INT0}, 8'h01);
    chk("rt_int1_b1", {7'b0, INT1}, 8'h00);
    pulse(8'h80, 2);
    chk("rt_int0_b7", {7'b0, INT0}, 8'h01);
    chk("rt_int1_b7", {7'b0, INT1}, 8'h01);
    rd("rt_pend", 8'h10, 8'h82);
    wr(8'h10, 8'h02);
    tick();
    chk("rt_int0_clr", {7'b0, INT0}, 8'h00);
    chk("rt_int1_keep", {7'b0, INT1}, 8'h01);
    wr(8'h10, 8'h80);
    tick();
    chk("rt_int1_clr", {7'b0, INT1}, 8'h00);

    // Level mode: clearing while the line is high is ineffective.
    wr(8'h13, 8'h00);
    wr(8'h11, 8'h04);
    wr(8'h12, 8'h00);
    IRQ_IN = 8'h04;
    repeat (5) tick();
    chk("lvl_int0_up", {7'b0, INT0}, 8'h01);
    wr(8'h10, 8'h04);
    step("lvl_pend_reset", 8'h04);
    chk("lvl_int0_stays", {7'b0, INT0}, 8'h01);
    IRQ_IN = 8'h00;
    repeat (3) tick();
    wr(8'h10, 8'h04);
    step("lvl_pend_clr", 8'h00);
    chk("lvl_int0_down", {7'b0, INT0}, 8'h00);

    // Collision: W1C lands on the same edge as rise[3]; set wins.
    wr(8'h13, 8'h08);
    wr(8'h11, 8'h08);
    IRQ_IN = 8'h08;
    tick();
    tick();
    wr(8'h10, 8'h08);
    step("col_pend", 8'h08);
    chk("col_int0", {7'b0, INT0}, 8'h01);
    IRQ_IN = 8'h00;
    repeat (3) tick();
    wr(8'h10, 8'h08);
    step("col_pend_clr", 8'h00);
    chk("col_int0_clr", {7'b0, INT0}, 8'h00);

    // Decode: out-of-window writes ignored; reads of each register and unmapped ports.
    wr(8'h11, 8'hA5);
    wr(8'h12, 8'h5A);
    wr(8'h13, 8'h3C);
    wr(8'h14, 8'h55);
    wr(8'h0F, 8'h55);
    wr(8'h0C, 8'hFF);
    rd("dec_mask", 8'h11, 8'hA5);
    step("dec_mask_hold", 8'hA5);
    rd("dec_route", 8'h12, 8'h5A);
    rd("dec_edge", 8'h13, 8'h3C);
    rd("dec_pend", 8'h10, 8'h00);
    rd("dec_unmap14", 8'h14, 8'h00);
    rd("dec_unmap20", 8'h20, 8'h00);
    chk("dec_int0", {7'b0, INT0}, 8'h00);
    chk("dec_int1", {7'b0, INT1}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
